// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit definitions: sequencer state encoding and default counter geometry.
// No logic, so no latency; nothing here exerts backpressure.
package cpu_ctrl_pkg;

    localparam int DEF_STEPS      = 4;
    localparam int DEF_MAX_CYCLES = 8;
    localparam int DEF_LEN_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } seq_state_t;

endpackage

// File: rtl/one_hot_ring.sv
// One-hot ring counter: rotates one position per enabled clock, holds its value when disabled.
// Outputs are registered (zero added latency); backpressure is the caller dropping i_En.
module one_hot_ring #(
    parameter int WIDTH = 4
) (
    input  logic             i_Clk,
    input  logic             i_Reset_n,
    input  logic             i_En,
    output logic [WIDTH-1:0] o_Ring,
    output logic             o_Last
);

    logic [WIDTH-1:0] r_ring;

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_ring <= WIDTH'(1);
        end else if (i_En) begin
            r_ring <= {r_ring[WIDTH-2:0], r_ring[WIDTH-1]};
        end
    end

    assign o_Ring = r_ring;
    assign o_Last = r_ring[WIDTH-1];

endmodule

// File: rtl/x_group_cycle_sequencer.sv
// T-step / M-cycle sequencer for one opcode x-group; i_Start -> o_Active is one clock.
// i_Mem_Ready low at the last T-step freezes step and cycle (STALL) until it returns high.
module x_group_cycle_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int                     STEPS      = DEF_STEPS,
    parameter int                     MAX_CYCLES = DEF_MAX_CYCLES,
    parameter int                     N_OPS      = 8,
    parameter int                     LEN_W      = DEF_LEN_W,
    parameter logic [LEN_W*N_OPS-1:0] LEN_TAKEN  = {N_OPS{LEN_W'(1)}},
    parameter logic [LEN_W*N_OPS-1:0] LEN_SKIP   = {N_OPS{LEN_W'(1)}},
    parameter logic [N_OPS-1:0]       COND_MASK  = '0,
    parameter int                     COND_CYCLE = 1
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset_n,
    input  logic                  i_Start,
    input  logic [N_OPS-1:0]      i_Op_Sel,
    input  logic                  i_Cond_Met,
    input  logic                  i_Mem_Ready,
    output logic [STEPS-1:0]      o_Cycle_Step,
    output logic [MAX_CYCLES-1:0] o_Cycle_Count,
    output logic                  o_Active,
    output logic                  o_Fetch,
    output logic                  o_Stall,
    output logic                  o_Cond_Skip
);

    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_CYCLES);
    localparam logic [LEN_W-1:0] COND_IDX = LEN_W'(COND_CYCLE);

    seq_state_t       r_state, w_state_nxt;
    logic [LEN_W-1:0] r_idx, w_idx_nxt;
    logic [LEN_W-1:0] r_len, w_len_nxt;
    logic [LEN_W-1:0] r_skip_len, w_skip_len_nxt;
    logic             r_cond, w_cond_nxt;
    logic             r_cond_skip, w_cond_skip_nxt;

    logic             w_step_en;
    logic             w_last_step;
    logic [STEPS-1:0] w_step;
    logic             w_load;

    logic             w_op_valid;
    logic             w_start_ok;
    logic [LEN_W-1:0] w_sel_taken, w_sel_skip;
    logic             w_sel_cond;

    logic             w_shorten;
    logic [LEN_W-1:0] w_len_eff;
    logic [LEN_W:0]   w_idx_p1;
    logic             w_final;

    // Table lengths of zero or beyond the cycle vector are clamped so Count never wraps or empties.
    function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len);
        if (len == '0) begin
            return LEN_W'(1);
        end
        if (len > MAX_LEN) begin
            return MAX_LEN;
        end
        return len;
    endfunction

    one_hot_ring #(
        .WIDTH (STEPS)
    ) u_step_ring (
        .i_Clk     (i_Clk),
        .i_Reset_n (i_Reset_n),
        .i_En      (w_step_en),
        .o_Ring    (w_step),
        .o_Last    (w_last_step)
    );

    assign w_op_valid = (i_Op_Sel != '0) && ((i_Op_Sel & (i_Op_Sel - N_OPS'(1))) == '0);
    assign w_start_ok = i_Start && w_op_valid;

    always_comb begin
        w_sel_taken = '0;
        w_sel_skip  = '0;
        w_sel_cond  = 1'b0;
        for (int n = 0; n < N_OPS; n++) begin
            if (i_Op_Sel[n]) begin
                w_sel_taken = w_sel_taken | LEN_TAKEN[n*LEN_W +: LEN_W];
                w_sel_skip  = w_sel_skip  | LEN_SKIP[n*LEN_W +: LEN_W];
                w_sel_cond  = w_sel_cond  | COND_MASK[n];
            end
        end
    end

    // A failed condition may cut the op at or below the current cycle; then this cycle is final.
    assign w_shorten = r_cond && (r_idx == COND_IDX) && !i_Cond_Met;
    assign w_len_eff = w_shorten ? r_skip_len : r_len;
    assign w_idx_p1  = {1'b0, r_idx} + (LEN_W+1)'(1);
    assign w_final   = (w_idx_p1 >= {1'b0, w_len_eff});

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_len_nxt       = r_len;
        w_skip_len_nxt  = r_skip_len;
        w_cond_nxt      = r_cond;
        w_cond_skip_nxt = 1'b0;
        w_step_en       = 1'b1;
        w_load          = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (w_last_step && w_start_ok) begin
                    w_load = 1'b1;
                end
            end
            ST_RUN, ST_STALL: begin
                if (w_last_step) begin
                    if (!i_Mem_Ready) begin
                        w_state_nxt = ST_STALL;
                        w_step_en   = 1'b0;
                    end else begin
                        if (w_shorten) begin
                            w_len_nxt       = r_skip_len;
                            w_cond_skip_nxt = 1'b1;
                        end
                        if (!w_final) begin
                            w_state_nxt = ST_RUN;
                            w_idx_nxt   = r_idx + LEN_W'(1);
                        end else if (w_start_ok) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_nxt = ST_IDLE;
                            w_idx_nxt   = '0;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
            end
        endcase

        if (w_load) begin
            w_state_nxt    = ST_RUN;
            w_idx_nxt      = '0;
            w_len_nxt      = sat_len(w_sel_taken);
            w_skip_len_nxt = sat_len(w_sel_skip);
            w_cond_nxt     = w_sel_cond;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_len       <= LEN_W'(1);
            r_skip_len  <= LEN_W'(1);
            r_cond      <= 1'b0;
            r_cond_skip <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_len       <= w_len_nxt;
            r_skip_len  <= w_skip_len_nxt;
            r_cond      <= w_cond_nxt;
            r_cond_skip <= w_cond_skip_nxt;
        end
    end

    assign o_Cycle_Step  = w_step;
    assign o_Cycle_Count = MAX_CYCLES'(1) << r_idx;
    assign o_Active      = (r_state != ST_IDLE);
    assign o_Fetch       = (r_state == ST_IDLE) || (w_idx_p1 == {1'b0, r_len});
    assign o_Stall       = (r_state == ST_STALL);
    assign o_Cond_Skip   = r_cond_skip;

endmodule

// File: tb/tb_x_group_cycle_sequencer.sv
// Bench for x_group_cycle_sequencer: directed vector table, async-reset sequence, then random
// stimulus compared each clock against a cycle-level integer reference model.
module tb_x_group_cycle_sequencer;

    localparam int STEPS = 4;
    localparam int MAXC  = 8;
    localparam int NOPS  = 8;
    localparam int CONDC = 1;

    logic       i_Clk       = 1'b0;
    logic       i_Reset_n   = 1'b1;
    logic       i_Start     = 1'b0;
    logic [7:0] i_Op_Sel    = 8'h00;
    logic       i_Cond_Met  = 1'b0;
    logic       i_Mem_Ready = 1'b1;
    logic [3:0] o_Cycle_Step;
    logic [7:0] o_Cycle_Count;
    logic       o_Active, o_Fetch, o_Stall, o_Cond_Skip;

    int errors = 0;
    int checks = 0;

    x_group_cycle_sequencer #(
        .STEPS      (STEPS),
        .MAX_CYCLES (MAXC),
        .N_OPS      (NOPS),
        .LEN_W      (4),
        .LEN_TAKEN  ({4'd5, 4'd5, 4'd12, 4'd4, 4'd2, 4'd3, 4'd3, 4'd1}),
        .LEN_SKIP   ({4'd1, 4'd3, 4'd1, 4'd1, 4'd1, 4'd2, 4'd1, 4'd1}),
        .COND_MASK  (8'b0101_0100),
        .COND_CYCLE (CONDC)
    ) dut (
        .i_Clk         (i_Clk),
        .i_Reset_n     (i_Reset_n),
        .i_Start       (i_Start),
        .i_Op_Sel      (i_Op_Sel),
        .i_Cond_Met    (i_Cond_Met),
        .i_Mem_Ready   (i_Mem_Ready),
        .o_Cycle_Step  (o_Cycle_Step),
        .o_Cycle_Count (o_Cycle_Count),
        .o_Active      (o_Active),
        .o_Fetch       (o_Fetch),
        .o_Stall       (o_Stall),
        .o_Cond_Skip   (o_Cond_Skip)
    );

    always #5 i_Clk = ~i_Clk;

    // Op table as seen by the model (index = op slot).
    int tk[8] = '{1, 3, 3, 2, 4, 12, 5, 5};
    int sk[8] = '{1, 1, 2, 1, 1, 1, 3, 1};
    bit cm[8] = '{0, 0, 1, 0, 1, 0, 1, 0};

    int m_step, m_cyc, m_len, m_skip;
    bit m_busy, m_stalled, m_cond, m_pulse;

    typedef struct {
        int         ncyc;
        logic       start;
        logic [7:0] sel;
        logic       cond;
        logic       rdy;
        logic [3:0] step;
        logic [7:0] cnt;
        logic       act;
        logic       fet;
        logic       stl;
        logic       skp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int n, input logic s, input logic [7:0] sel, input logic c,
                       input logic r, input logic [3:0] st, input logic [7:0] cn,
                       input logic a, input logic f, input logic sl, input logic sp);
        vec_t v;
        v.ncyc = n; v.start = s; v.sel = sel; v.cond = c; v.rdy = r;
        v.step = st; v.cnt = cn; v.act = a; v.fet = f; v.stl = sl; v.skp = sp;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] e_step, input logic [7:0] e_cnt,
                         input logic e_act, input logic e_fet, input logic e_stl, input logic e_skp);
        logic [15:0] got, exp;
        got = {o_Cycle_Step, o_Cycle_Count, o_Active, o_Fetch, o_Stall, o_Cond_Skip};
        exp = {e_step, e_cnt, e_act, e_fet, e_stl, e_skp};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got step=%h count=%h act=%b fetch=%b stall=%b skip=%b, want step=%h count=%h act=%b fetch=%b stall=%b skip=%b",
                     name, $time, o_Cycle_Step, o_Cycle_Count, o_Active, o_Fetch, o_Stall, o_Cond_Skip,
                     e_step, e_cnt, e_act, e_fet, e_stl, e_skp);
        end
    endtask

    function automatic int clamp_len(input int l);
        if (l < 1) return 1;
        if (l > MAXC) return MAXC;
        return l;
    endfunction

    task automatic model_reset();
        m_step = 0; m_cyc = 0; m_len = 1; m_skip = 1;
        m_busy = 0; m_stalled = 0; m_cond = 0; m_pulse = 0;
    endtask

    // Begin a new op if the select names exactly one slot; returns whether it started.
    function automatic bit model_try_load();
        if (!i_Start || $countones(i_Op_Sel) != 1) return 0;
        for (int n = 0; n < NOPS; n++) begin
            if (i_Op_Sel[n]) begin
                m_len  = clamp_len(tk[n]);
                m_skip = clamp_len(sk[n]);
                m_cond = cm[n];
            end
        end
        m_busy = 1;
        m_cyc  = 0;
        return 1;
    endfunction

    task automatic model_clock();
        bit last;
        if (!i_Reset_n) begin
            model_reset();
            return;
        end
        last    = (m_step == STEPS - 1);
        m_pulse = 0;
        if (!m_busy) begin
            if (last) void'(model_try_load());
            m_step = (m_step + 1) % STEPS;
        end else if (!last) begin
            m_step++;
        end else if (!i_Mem_Ready) begin
            m_stalled = 1;
        end else begin
            m_stalled = 0;
            m_step    = 0;
            if (m_cond && m_cyc == CONDC && !i_Cond_Met) begin
                m_len   = m_skip;
                m_pulse = 1;
            end
            if (m_cyc + 1 >= m_len) begin
                if (!model_try_load()) begin
                    m_busy = 0;
                    m_cyc  = 0;
                end
            end else begin
                m_cyc++;
            end
        end
    endtask

    task automatic check_model(input string name);
        check(name, 4'(1 << m_step), 8'(1 << m_cyc), m_busy,
              !m_busy || (m_cyc == m_len - 1), m_stalled, m_pulse);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;

        //   ncyc st  sel   cnd rdy  step  count  act fet stl skp
        add(3,  1, 8'h00, 0, 1, 4'h8, 8'h01, 0, 1, 0, 0);
        add(1,  1, 8'h00, 0, 1, 4'h1, 8'h01, 0, 1, 0, 0);
        add(4,  1, 8'h03, 0, 1, 4'h1, 8'h01, 0, 1, 0, 0);
        add(4,  1, 8'h02, 0, 1, 4'h1, 8'h01, 1, 0, 0, 0);
        add(3,  0, 8'h00, 0, 1, 4'h8, 8'h01, 1, 0, 0, 0);
        add(1,  0, 8'h00, 0, 1, 4'h1, 8'h02, 1, 0, 0, 0);
        add(4,  0, 8'h00, 0, 1, 4'h1, 8'h04, 1, 1, 0, 0);
        add(3,  0, 8'h00, 0, 1, 4'h8, 8'h04, 1, 1, 0, 0);
        add(1,  0, 8'h00, 0, 1, 4'h1, 8'h01, 0, 1, 0, 0);
        add(4,  1, 8'h04, 0, 1, 4'h1, 8'h01, 1, 0, 0, 0);
        add(4,  0, 8'h00, 0, 1, 4'h1, 8'h02, 1, 0, 0, 0);
        add(4,  0, 8'h00, 0, 1, 4'h1, 8'h01, 0, 1, 0, 1);
        add(1,  0, 8'h00, 0, 1, 4'h2, 8'h01, 0, 1, 0, 0);
        add(2,  1, 8'h02, 0, 1, 4'h8, 8'h01, 0, 1, 0, 0);
        add(1,  1, 8'h02, 0, 1, 4'h1, 8'h01, 1, 0, 0, 0);
        add(4,  0, 8'h00, 0, 1, 4'h1, 8'h02, 1, 0, 0, 0);
        add(3,  0, 8'h00, 0, 1, 4'h8, 8'h02, 1, 0, 0, 0);
        add(1,  0, 8'h00, 0, 0, 4'h8, 8'h02, 1, 0, 1, 0);
        add(2,  0, 8'h00, 0, 0, 4'h8, 8'h02, 1, 0, 1, 0);
        add(1,  0, 8'h00, 0, 1, 4'h1, 8'h04, 1, 1, 0, 0);
        add(3,  0, 8'h00, 0, 0, 4'h8, 8'h04, 1, 1, 0, 0);
        add(1,  1, 8'h08, 0, 1, 4'h1, 8'h01, 1, 0, 0, 0);
        add(4,  0, 8'h00, 0, 1, 4'h1, 8'h02, 1, 1, 0, 0);
        add(3,  1, 8'h01, 0, 1, 4'h8, 8'h02, 1, 1, 0, 0);
        add(1,  1, 8'h01, 0, 1, 4'h1, 8'h01, 1, 1, 0, 0);
        add(4,  0, 8'h00, 0, 1, 4'h1, 8'h01, 0, 1, 0, 0);
        add(3,  0, 8'h00, 0, 1, 4'h8, 8'h01, 0, 1, 0, 0);
        add(1,  1, 8'h20, 0, 1, 4'h1, 8'h01, 1, 0, 0, 0);
        add(28, 0, 8'h00, 0, 1, 4'h1, 8'h80, 1, 1, 0, 0);
        add(4,  0, 8'h00, 0, 1, 4'h1, 8'h01, 0, 1, 0, 0);
        add(4,  1, 8'h10, 0, 1, 4'h1, 8'h01, 1, 0, 0, 0);
        add(8,  0, 8'h00, 0, 1, 4'h1, 8'h01, 0, 1, 0, 1);
        add(4,  1, 8'h04, 1, 1, 4'h1, 8'h01, 1, 0, 0, 0);
        add(8,  0, 8'h00, 1, 1, 4'h1, 8'h04, 1, 1, 0, 0);
        add(4,  0, 8'h00, 1, 1, 4'h1, 8'h01, 0, 1, 0, 0);

        #1 i_Reset_n = 1'b0;
        @(negedge i_Clk);
        check("reset_state", 4'h1, 8'h01, 0, 1, 0, 0);
        i_Reset_n = 1'b1;

        foreach (tbl[i]) begin
            i_Start     = tbl[i].start;
            i_Op_Sel    = tbl[i].sel;
            i_Cond_Met  = tbl[i].cond;
            i_Mem_Ready = tbl[i].rdy;
            repeat (tbl[i].ncyc) @(posedge i_Clk);
            @(negedge i_Clk);
            check($sformatf("vec%0d", i), tbl[i].step, tbl[i].cnt, tbl[i].act,
                  tbl[i].fet, tbl[i].stl, tbl[i].skp);
        end

        // Asynchronous reset in the middle of a running op.
        i_Start = 1'b1; i_Op_Sel = 8'h02; i_Mem_Ready = 1'b1; i_Cond_Met = 1'b0;
        repeat (4) @(posedge i_Clk);
        @(negedge i_Clk);
        i_Start = 1'b0; i_Op_Sel = 8'h00;
        repeat (9) @(posedge i_Clk);
        @(negedge i_Clk);
        check("pre_reset", 4'h2, 8'h04, 1, 1, 0, 0);
        #2 i_Reset_n = 1'b0;
        #1 check("async_reset", 4'h1, 8'h01, 0, 1, 0, 0);
        @(negedge i_Clk);
        check("reset_hold", 4'h1, 8'h01, 0, 1, 0, 0);
        i_Reset_n = 1'b1;
        model_reset();

        for (int k = 0; k < 3000; k++) begin
            i_Start = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            if (r < 8)       i_Op_Sel = 8'(1 << r);
            else if (r == 8) i_Op_Sel = 8'h00;
            else             i_Op_Sel = 8'($urandom);
            i_Cond_Met  = ($urandom_range(0, 1) != 0);
            i_Mem_Ready = ($urandom_range(0, 3) != 0);
            i_Reset_n   = ($urandom_range(0, 249) != 0);
            @(posedge i_Clk);
            model_clock();
            @(negedge i_Clk);
            check_model("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
